muldiv: RTL and testbench

Multi-cycle multiply/divide unit owning the HI/LO registers. It executes the `mult`, `multu`, `div` and `divu` instructions flagged by the instruction decoder, and services `mthi`/`mtlo` writes. It sits beside the ALU in the execute stage. The pipeline stalls while `busy` is high and reads `hi`/`lo` directly for `mfhi`/`mflo`.

---
 rtl/muldiv.sv | 181 ++++++++++++++++++
 tb/tb_muldiv.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv.sv
// rtl/muldiv.sv - Multi-cycle multiply/divide unit owning the HI/LO registers
//
// Executes mult/multu/div/divu (op = func[1:0]) and mthi/mtlo writes.
// Optional feature macro: MULDIV_FAST_MUL_EN (single-cycle multiply path;
// division stays iterative). Default build: all ops take 33 busy cycles.
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   start   launch an operation (accepted in IDLE, or in FIX for back-to-back)
//   op      00 mult, 01 multu, 10 div, 11 divu
//   a, b    rs / rt operands, sampled only when the operation is accepted
//   wen_hi  mthi strobe (IDLE only)
//   wen_lo  mtlo strobe (IDLE only)
//   wdata   mthi/mtlo data
//   hi, lo  HI/LO registers
//   busy    operation in flight; pipeline stalls
//   done    one-cycle pulse after hi/lo take a result
module muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        wen_hi,
  input  logic        wen_lo,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state;
  logic [1:0]  op_q;
  logic [31:0] a_raw;     // original dividend, returned in HI on divide by zero
  logic        neg_q;     // negate product / quotient
  logic        neg_r;     // negate remainder (dividend sign)
  logic [5:0]  cnt;

  // multiply datapath
  logic [63:0] acc;
  logic [63:0] mcand;
  logic [31:0] mplier;

  // divide datapath
  logic [31:0] rem;
  logic [31:0] quo;       // starts as dividend, shifts out MSB first, fills with quotient bits
  logic [31:0] divisor;

  // operand preparation at launch
  logic        is_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        accept;

  assign is_signed = ~op[0];
  assign a_neg     = is_signed & a[31];
  assign b_neg     = is_signed & b[31];
  assign a_mag     = a_neg ? (~a + 32'd1) : a;
  assign b_mag     = b_neg ? (~b + 32'd1) : b;

  // FIX also accepts a start so a new op can issue in the cycle the result lands
  assign accept = start & ((state == IDLE) | (state == FIX));
  assign busy   = (state != IDLE);

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] fast_prod;
  assign fast_prod = {32'd0, a_mag} * {32'd0, b_mag};
`endif

  // Restoring division step: 33-bit partial remainder formed by shifting in the
  // next dividend bit. When the subtraction succeeds the result is below the
  // divisor, so the low 32 bits of the difference are exact.
  logic [32:0] rem_sh;
  logic        rem_ge;
  logic [31:0] rem_next;
  logic [31:0] quo_next;

  always_comb begin
    rem_sh   = {rem, quo[31]};
    rem_ge   = (rem_sh >= {1'b0, divisor});
    rem_next = rem_ge ? (rem_sh[31:0] - divisor) : rem_sh[31:0];
    quo_next = {quo[30:0], rem_ge};
  end

  // Sign fix-up and special cases applied in FIX
  logic [63:0] prod_fix;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  always_comb begin
    prod_fix = neg_q ? (~acc + 64'd1) : acc;
    res_hi   = prod_fix[63:32];
    res_lo   = prod_fix[31:0];
    if (op_q[1]) begin
      if (divisor == 32'd0) begin
        res_hi = a_raw;
        res_lo = 32'hFFFF_FFFF;
      end else begin
        res_hi = neg_r ? (~rem + 32'd1) : rem;
        res_lo = neg_q ? (~quo + 32'd1) : quo;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      op_q    <= 2'd0;
      a_raw   <= 32'd0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      cnt     <= 6'd0;
      acc     <= 64'd0;
      mcand   <= 64'd0;
      mplier  <= 32'd0;
      rem     <= 32'd0;
      quo     <= 32'd0;
      divisor <= 32'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (wen_hi) hi <= wdata;
          if (wen_lo) lo <= wdata;
        end
        CALC: begin
          if (op_q[1]) begin
            rem <= rem_next;
            quo <= quo_next;
          end else begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) state <= FIX;
        end
        FIX: begin
          hi    <= res_hi;
          lo    <= res_lo;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Launch overrides the state transition above (IDLE or FIX only)
      if (accept) begin
        op_q    <= op;
        a_raw   <= a;
        neg_q   <= a_neg ^ b_neg;
        neg_r   <= a_neg;
        cnt     <= 6'd0;
        acc     <= 64'd0;
        mcand   <= {32'd0, a_mag};
        mplier  <= b_mag;
        rem     <= 32'd0;
        quo     <= a_mag;
        divisor <= b_mag;
        state   <= CALC;
`ifdef MULDIV_FAST_MUL_EN
        if (!op[1]) begin
          acc   <= fast_prod;
          state <= FIX;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_muldiv.sv
// tb/tb_muldiv.sv - Self-checking bench for muldiv against an arithmetic reference model
module tb_muldiv;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        wen_hi;
  logic        wen_lo;
  logic [31:0] wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  muldiv dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .wen_hi(wen_hi), .wen_lo(wen_lo), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {HI, LO} from plain arithmetic
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] r;
    longint      sp;
    int          sx;
    int          sy;
    sx = x;
    sy = y;
    r  = 64'd0;
    case (o)
      2'd0: begin sp = longint'(sx) * longint'(sy); r = sp; end
      2'd1: r = {32'd0, x} * {32'd0, y};
      2'd2: begin
        if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
        else r = {sx % sy, sx / sy};
      end
      default: begin
        if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
        else r = {x % y, x / y};
      end
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [1:0] o);
    return o[1] ? DIV_LAT : MUL_LAT;
  endfunction

  // Issue one op and measure busy cycles and done pulses; operands are scrambled after E0
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output int pulses, output logic [31:0] rh, output logic [31:0] rl);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = $urandom; b = $urandom;
    lat = 0;
    pulses = 0;
    @(negedge clk);
    while (busy && lat < 100) begin
      lat++;
      if (done) pulses++;
      @(negedge clk);
    end
    if (done) pulses++;
    rh = hi;
    rl = lo;
    @(negedge clk);
    if (done) pulses++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if (hi !== 32'd0) begin n_bad++; $display("FAIL reset_hi got=%h exp=0", hi); end
    n_cmp++; if (lo !== 32'd0) begin n_bad++; $display("FAIL reset_lo got=%h exp=0", lo); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_op(input string name, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int lat, pulses;
    logic [31:0] rh, rl;
    logic [63:0] e;
    e = model(o, x, y);
    do_op(o, x, y, lat, pulses, rh, rl);
    n_cmp++; if (lat !== exp_lat(o)) begin n_bad++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, exp_lat(o)); end
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL %s_done_pulses got=%0d exp=1", name, pulses); end
    n_cmp++; if (rh !== e[63:32]) begin n_bad++; $display("FAIL %s_hi op=%0d a=%h b=%h got=%h exp=%h", name, o, x, y, rh, e[63:32]); end
    n_cmp++; if (rl !== e[31:0]) begin n_bad++; $display("FAIL %s_lo op=%0d a=%h b=%h got=%h exp=%h", name, o, x, y, rl, e[31:0]); end
  endtask

  task automatic test_mult_directed();
    int lat, pulses;
    logic [31:0] rh, rl;
    do_op(2'd0, 32'hFFFF_FFFD, 32'd7, lat, pulses, rh, rl);
    n_cmp++; if (lat !== MUL_LAT) begin n_bad++; $display("FAIL mult_latency got=%0d exp=%0d", lat, MUL_LAT); end
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL mult_done got=%0d exp=1", pulses); end
    n_cmp++; if (rh !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mult_hi got=%h exp=ffffffff", rh); end
    n_cmp++; if (rl !== 32'hFFFF_FFEB) begin n_bad++; $display("FAIL mult_lo got=%h exp=ffffffeb", rl); end
    do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, pulses, rh, rl);
    n_cmp++; if (rh !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL multu_hi got=%h exp=fffffffe", rh); end
    n_cmp++; if (rl !== 32'h0000_0001) begin n_bad++; $display("FAIL multu_lo got=%h exp=00000001", rl); end
    do_op(2'd0, 32'd3, 32'd5, lat, pulses, rh, rl);
    n_cmp++; if (lat !== MUL_LAT) begin n_bad++; $display("FAIL mult35_latency got=%0d exp=%0d", lat, MUL_LAT); end
    n_cmp++; if ({rh, rl} !== 64'd15) begin n_bad++; $display("FAIL mult35_result got=%h exp=15", {rh, rl}); end
  endtask

  task automatic test_div_directed();
    int lat, pulses;
    logic [31:0] rh, rl;
    do_op(2'd2, 32'hFFFF_FFF9, 32'd2, lat, pulses, rh, rl);
    n_cmp++; if (lat !== DIV_LAT) begin n_bad++; $display("FAIL div_latency got=%0d exp=%0d", lat, DIV_LAT); end
    n_cmp++; if (rl !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_lo got=%h exp=fffffffd", rl); end
    n_cmp++; if (rh !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_hi got=%h exp=ffffffff", rh); end
    do_op(2'd3, 32'd100, 32'd7, lat, pulses, rh, rl);
    n_cmp++; if (rl !== 32'd14) begin n_bad++; $display("FAIL divu_lo got=%h exp=14", rl); end
    n_cmp++; if (rh !== 32'd2) begin n_bad++; $display("FAIL divu_hi got=%h exp=2", rh); end
    do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat, pulses, rh, rl);
    n_cmp++; if (rl !== 32'h8000_0000) begin n_bad++; $display("FAIL div_ovf_lo got=%h exp=80000000", rl); end
    n_cmp++; if (rh !== 32'd0) begin n_bad++; $display("FAIL div_ovf_hi got=%h exp=0", rh); end
    do_op(2'd3, 32'h1234, 32'd0, lat, pulses, rh, rl);
    n_cmp++; if (lat !== DIV_LAT) begin n_bad++; $display("FAIL divz_latency got=%0d exp=%0d", lat, DIV_LAT); end
    n_cmp++; if (rl !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL divuz_lo got=%h exp=ffffffff", rl); end
    n_cmp++; if (rh !== 32'h1234) begin n_bad++; $display("FAIL divuz_hi got=%h exp=1234", rh); end
    do_op(2'd2, 32'hFFFF_FF00, 32'd0, lat, pulses, rh, rl);
    n_cmp++; if (rl !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL divz_lo got=%h exp=ffffffff", rl); end
    n_cmp++; if (rh !== 32'hFFFF_FF00) begin n_bad++; $display("FAIL divz_hi got=%h exp=ffffff00", rh); end
  endtask

  task automatic test_reset_mid_op();
    int lat, pulses;
    logic [31:0] rh, rl;
    @(negedge clk);
    wen_hi = 1'b1; wen_lo = 1'b1; wdata = 32'h5555_AAAA;
    @(negedge clk);
    wen_hi = 1'b0; wen_lo = 1'b0;
    op = 2'd3; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre_busy got=%b exp=1", busy); end
    rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rstmid_done got=%b exp=0", done); end
    n_cmp++; if (hi !== 32'd0) begin n_bad++; $display("FAIL rstmid_hi got=%h exp=0", hi); end
    n_cmp++; if (lo !== 32'd0) begin n_bad++; $display("FAIL rstmid_lo got=%h exp=0", lo); end
    @(negedge clk);
    rst = 1'b0;
    do_op(2'd3, 32'd1000, 32'd3, lat, pulses, rh, rl);
    n_cmp++; if (lat !== DIV_LAT) begin n_bad++; $display("FAIL rstmid_after_latency got=%0d exp=%0d", lat, DIV_LAT); end
    n_cmp++; if ({rh, rl} !== {32'd1, 32'd333}) begin n_bad++; $display("FAIL rstmid_after_result got=%h exp=%h", {rh, rl}, {32'd1, 32'd333}); end
  endtask

  task automatic test_busy_stimuli();
    logic [1:0]  o;
    logic [63:0] e;
    int          n;
    o = (MUL_LAT == 1) ? 2'd3 : 2'd0;
    e = model(o, 32'h1234_5678, 32'h9ABC);
    @(negedge clk);
    op = o; a = 32'h1234_5678; b = 32'h9ABC; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      n++;
      if (n == 5) begin
        start = 1'b1; op = 2'd1; a = 32'hFFFF_0000; b = 32'h0000_FFFF;
        wen_hi = 1'b1; wen_lo = 1'b1; wdata = 32'hDEAD_BEEF;
      end
      if (n == 6) begin
        start = 1'b0; wen_hi = 1'b0; wen_lo = 1'b0;
      end
      @(negedge clk);
    end
    n_cmp++; if (n !== exp_lat(o)) begin n_bad++; $display("FAIL busystim_latency got=%0d exp=%0d", n, exp_lat(o)); end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL busystim_done got=%b exp=1", done); end
    n_cmp++; if ({hi, lo} !== e) begin n_bad++; $display("FAIL busystim_result got=%h exp=%h", {hi, lo}, e); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL busystim_no_queue got=%b exp=0", busy); end
  endtask

  task automatic test_mthi_mtlo();
    int n;
    @(negedge clk);
    wen_hi = 1'b1; wdata = 32'hCAFE_BABE;
    @(posedge clk);
    #1;
    wen_hi = 1'b0; wdata = 32'd0;
    @(negedge clk);
    n_cmp++; if (hi !== 32'hCAFE_BABE) begin n_bad++; $display("FAIL mthi got=%h exp=cafebabe", hi); end
    wen_lo = 1'b1; wdata = 32'h0BAD_F00D;
    @(negedge clk);
    wen_lo = 1'b0;
    n_cmp++; if (lo !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL mtlo got=%h exp=0badf00d", lo); end
    n_cmp++; if (hi !== 32'hCAFE_BABE) begin n_bad++; $display("FAIL mtlo_hi_kept got=%h exp=cafebabe", hi); end
    wen_hi = 1'b1; wen_lo = 1'b1; wdata = 32'h1357_2468;
    @(negedge clk);
    wen_hi = 1'b0; wen_lo = 1'b0;
    n_cmp++; if ({hi, lo} !== {32'h1357_2468, 32'h1357_2468}) begin n_bad++; $display("FAIL mthilo_both got=%h exp=%h", {hi, lo}, {32'h1357_2468, 32'h1357_2468}); end
    // strobe and start together: strobe lands first, result overwrites at FIX
    start = 1'b1; op = 2'd3; a = 32'd100; b = 32'd7; wen_lo = 1'b1; wdata = 32'h77;
    @(negedge clk);
    start = 1'b0; wen_lo = 1'b0;
    n_cmp++; if (lo !== 32'h77) begin n_bad++; $display("FAIL strobe_start_lo got=%h exp=77", lo); end
    n = 0;
    while (busy && n < 100) begin n++; @(negedge clk); end
    n_cmp++; if ({hi, lo} !== {32'd2, 32'd14}) begin n_bad++; $display("FAIL strobe_start_result got=%h exp=%h", {hi, lo}, {32'd2, 32'd14}); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] e1, e2;
    int          nb, lat2;
    e1 = model(2'd3, 32'hF000_0001, 32'd9);
    e2 = model(2'd2, 32'h8765_4321, 32'hFFFF_FFF3);
    @(negedge clk);
    op = 2'd3; a = 32'hF000_0001; b = 32'd9; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    nb = 0;
    for (int i = 1; i <= 33; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (i == 33) begin
        start = 1'b1; op = 2'd2; a = 32'h8765_4321; b = 32'hFFFF_FFF3;
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    n_cmp++; if (nb !== 33) begin n_bad++; $display("FAIL b2b_first_busy got=%0d exp=33", nb); end
    @(negedge clk);
    n_cmp++; if ({busy, done} !== 2'b11) begin n_bad++; $display("FAIL b2b_busy_done got=%b exp=11", {busy, done}); end
    n_cmp++; if ({hi, lo} !== e1) begin n_bad++; $display("FAIL b2b_first_result got=%h exp=%h", {hi, lo}, e1); end
    lat2 = 1;
    @(negedge clk);
    while (busy && lat2 < 100) begin lat2++; @(negedge clk); end
    n_cmp++; if (lat2 !== 33) begin n_bad++; $display("FAIL b2b_second_latency got=%0d exp=33", lat2); end
    n_cmp++; if ({hi, lo} !== e2) begin n_bad++; $display("FAIL b2b_second_result got=%h exp=%h", {hi, lo}, e2); end
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] x, y;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: y = 32'($urandom_range(1, 15));
        3: begin x = -x; y = 32'($urandom_range(0, 3)) - 32'd2; end
        default: ;
      endcase
      check_op("random", o, x, y);
    end
  endtask

  initial begin
    start = 1'b0; op = 2'd0; a = 32'd0; b = 32'd0;
    wen_hi = 1'b0; wen_lo = 1'b0; wdata = 32'd0;
    rst = 1'b1;
    test_reset();
    test_mult_directed();
    test_div_directed();
    test_reset_mid_op();
    test_busy_stimuli();
    test_mthi_mtlo();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
